// File: rtl/pifo_calendar_pkg.sv
// Shared types and constants for the PIFO calendar: default widths, element layout,
// info-bus field offsets, full-policy encodings and per-slot action select.
package pifo_calendar_pkg;

  localparam int DEF_RANK_W  = 19;
  localparam int DEF_FIELD_W = 12;

  localparam int FULL_DROP_IN   = 0;
  localparam int FULL_EVICT_MAX = 1;

  localparam int FIELD_LSB = 0;

  typedef struct packed {
    logic                   valid;
    logic [DEF_RANK_W-1:0]  rank;
    logic [DEF_FIELD_W-1:0] field;
  } pifo_elem_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_POP,
    ACT_INSERT,
    ACT_REPLACE
  } cell_act_e;

  function automatic int rank_lsb(input int field_w);
    return FIELD_LSB + field_w;
  endfunction

  function automatic int valid_bit(input int rank_w, input int field_w);
    return rank_lsb(field_w) + rank_w;
  endfunction

endpackage

// File: rtl/pifo_calendar_cell.sv
// One calendar slot: selects its next content from itself, a neighbour or the new element.
// Latency: purely combinational; the top registers the result.
// Backpressure: none, the action select is decided once per cycle by the top.
module pifo_calendar_cell
  import pifo_calendar_pkg::*;
#(
  parameter int INFO_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic [INFO_W-1:0] left_elem,
  input  logic [INFO_W-1:0] right_elem,
  input  logic [INFO_W-1:0] cur_elem,
  input  logic [INFO_W-1:0] new_elem,
  input  logic [CNT_W-1:0]  idx,
  input  logic [CNT_W-1:0]  p,
  input  cell_act_e         act,
  output logic [INFO_W-1:0] nxt_elem
);

  logic [CNT_W-1:0] idx_p1;
  assign idx_p1 = idx + CNT_W'(1);

  always_comb begin
    nxt_elem = cur_elem;
    unique case (act)
      ACT_POP: nxt_elem = right_elem;
      ACT_INSERT: begin
        if (idx == p)     nxt_elem = new_elem;
        else if (idx > p) nxt_elem = left_elem;
      end
      // head leaves, so the insertion point moves one slot toward the head
      ACT_REPLACE: begin
        if (idx_p1 == p)     nxt_elem = new_elem;
        else if (idx_p1 < p) nxt_elem = right_elem;
      end
      default: nxt_elem = cur_elem;
    endcase
  end

endmodule

// File: rtl/pifo_calendar_v0_2.sv
// Rank-sorted PIFO calendar (FIFO among equal ranks) with bypass, drop report and occupancy.
// Latency: pop/drop results registered one cycle after the sampling edge; count updates same edge.
// Backpressure: none; a full calendar drops or evicts according to FULL_MODE.
module pifo_calendar_v0_2
  import pifo_calendar_pkg::*;
#(
  parameter int PIFO_CALENDAR_SIZE = 10,
  parameter int RANK_W             = DEF_RANK_W,
  parameter int FIELD_W            = DEF_FIELD_W,
  parameter int FULL_MODE          = FULL_DROP_IN,
  parameter int INFO_W             = 1 + RANK_W + FIELD_W
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [INFO_W-1:0]                         s_axis_pifo_info_root,
  input  logic                                      s_axis_insert_en,
  input  logic                                      s_axis_pop_en,
  output logic [FIELD_W-1:0]                        m_axis_buffer_addr,
  output logic                                      m_axis_buffer_addr_valid,
  output logic                                      m_axis_bypass_en,
  output logic                                      m_axis_drop_valid,
  output logic [FIELD_W-1:0]                        m_axis_drop_addr,
  output logic                                      m_axis_calendar_full,
  output logic                                      m_axis_calendar_empty,
  output logic [$clog2(PIFO_CALENDAR_SIZE+1)-1:0]   m_axis_count
);

  localparam int SIZE  = PIFO_CALENDAR_SIZE;
  localparam int CNT_W = $clog2(SIZE + 1);
  localparam int RLSB  = rank_lsb(FIELD_W);
  localparam int VBIT  = valid_bit(RANK_W, FIELD_W);

  logic [INFO_W-1:0]  slot_q [SIZE];
  logic [INFO_W-1:0]  slot_d [SIZE];
  logic [CNT_W-1:0]   count_q, count_d, p;
  logic [RANK_W-1:0]  new_rank, head_rank;
  logic [FIELD_W-1:0] new_field, head_field, tail_field;
  logic               ins_vld, empty, full;
  cell_act_e          act;
  logic               pop_vld, byp, drop_vld;
  logic [FIELD_W-1:0] pop_field, drop_field;

  assign new_rank   = s_axis_pifo_info_root[VBIT-1:RLSB];
  assign new_field  = s_axis_pifo_info_root[RLSB-1:FIELD_LSB];
  assign ins_vld    = s_axis_insert_en && s_axis_pifo_info_root[VBIT];
  assign head_rank  = slot_q[0][VBIT-1:RLSB];
  assign head_field = slot_q[0][RLSB-1:FIELD_LSB];
  assign tail_field = slot_q[SIZE-1][RLSB-1:FIELD_LSB];
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(SIZE));

  // insertion point: number of valid entries ranked at or below the newcomer
  always_comb begin
    p = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (slot_q[i][VBIT] && (slot_q[i][VBIT-1:RLSB] <= new_rank)) p = p + CNT_W'(1);
    end
  end

  always_comb begin
    act        = ACT_HOLD;
    count_d    = count_q;
    pop_vld    = 1'b0;
    byp        = 1'b0;
    pop_field  = head_field;
    drop_vld   = 1'b0;
    drop_field = new_field;
    if (ins_vld && s_axis_pop_en) begin
      pop_vld = 1'b1;
      if (empty || (new_rank < head_rank)) begin
        byp       = 1'b1;
        pop_field = new_field;
      end else begin
        act = ACT_REPLACE;
      end
    end else if (s_axis_pop_en) begin
      if (!empty) begin
        act     = ACT_POP;
        pop_vld = 1'b1;
        count_d = count_q - CNT_W'(1);
      end
    end else if (ins_vld) begin
      if (!full) begin
        act     = ACT_INSERT;
        count_d = count_q + CNT_W'(1);
      end else if ((FULL_MODE == FULL_EVICT_MAX) && (p != CNT_W'(SIZE))) begin
        act        = ACT_INSERT;
        drop_vld   = 1'b1;
        drop_field = tail_field;
      end else begin
        drop_vld = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_cell
    logic [INFO_W-1:0] left_e, right_e;
    if (i == 0) begin : g_head
      assign left_e = '0;
    end else begin : g_mid_l
      assign left_e = slot_q[i-1];
    end
    if (i == SIZE - 1) begin : g_tail
      assign right_e = '0;
    end else begin : g_mid_r
      assign right_e = slot_q[i+1];
    end
    pifo_calendar_cell #(
      .INFO_W (INFO_W),
      .CNT_W  (CNT_W)
    ) u_cell (
      .left_elem  (left_e),
      .right_elem (right_e),
      .cur_elem   (slot_q[i]),
      .new_elem   (s_axis_pifo_info_root),
      .idx        (CNT_W'(i)),
      .p          (p),
      .act        (act),
      .nxt_elem   (slot_d[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SIZE; i++) slot_q[i] <= '0;
      count_q                  <= '0;
      m_axis_buffer_addr       <= '0;
      m_axis_buffer_addr_valid <= 1'b0;
      m_axis_bypass_en         <= 1'b0;
      m_axis_drop_valid        <= 1'b0;
      m_axis_drop_addr         <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) slot_q[i] <= slot_d[i];
      count_q                  <= count_d;
      m_axis_buffer_addr_valid <= pop_vld;
      m_axis_bypass_en         <= byp;
      m_axis_drop_valid        <= drop_vld;
      if (pop_vld)  m_axis_buffer_addr <= pop_field;
      if (drop_vld) m_axis_drop_addr   <= drop_field;
    end
  end

  assign m_axis_count          = count_q;
  assign m_axis_calendar_full  = full;
  assign m_axis_calendar_empty = empty;

endmodule

// File: tb/tb_pifo_calendar_v0_2.sv
// Bench for pifo_calendar_v0_2: drop-tail and evict-max instances share one stimulus stream
// and are checked every cycle against a queue-based model, plus directed literal expectations.
module tb_pifo_calendar_v0_2;

  localparam int SIZE = 10;
  localparam int RW   = 19;
  localparam int FW   = 12;
  localparam int IW   = 1 + RW + FW;
  localparam int CW   = $clog2(SIZE + 1);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          ins_en = 1'b0, pop_en = 1'b0, in_valid = 1'b0;
  logic [RW-1:0] in_rank = '0;
  logic [FW-1:0] in_field = '0;
  logic [IW-1:0] info;
  assign info = {in_valid, in_rank, in_field};

  logic [FW-1:0] o_addr [2];
  logic [FW-1:0] o_daddr [2];
  logic          o_vld [2];
  logic          o_byp [2];
  logic          o_dvld [2];
  logic          o_full [2];
  logic          o_empty [2];
  logic [CW-1:0] o_cnt [2];

  pifo_calendar_v0_2 #(.PIFO_CALENDAR_SIZE(SIZE), .RANK_W(RW), .FIELD_W(FW), .FULL_MODE(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .s_axis_pifo_info_root(info), .s_axis_insert_en(ins_en),
    .s_axis_pop_en(pop_en), .m_axis_buffer_addr(o_addr[0]), .m_axis_buffer_addr_valid(o_vld[0]),
    .m_axis_bypass_en(o_byp[0]), .m_axis_drop_valid(o_dvld[0]), .m_axis_drop_addr(o_daddr[0]),
    .m_axis_calendar_full(o_full[0]), .m_axis_calendar_empty(o_empty[0]), .m_axis_count(o_cnt[0]));

  pifo_calendar_v0_2 #(.PIFO_CALENDAR_SIZE(SIZE), .RANK_W(RW), .FIELD_W(FW), .FULL_MODE(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .s_axis_pifo_info_root(info), .s_axis_insert_en(ins_en),
    .s_axis_pop_en(pop_en), .m_axis_buffer_addr(o_addr[1]), .m_axis_buffer_addr_valid(o_vld[1]),
    .m_axis_bypass_en(o_byp[1]), .m_axis_drop_valid(o_dvld[1]), .m_axis_drop_addr(o_daddr[1]),
    .m_axis_calendar_full(o_full[1]), .m_axis_calendar_empty(o_empty[1]), .m_axis_count(o_cnt[1]));

  typedef struct {
    int unsigned rank;
    int unsigned field;
  } e_t;

  e_t mq [2][$];
  bit e_vld [2];
  bit e_byp [2];
  bit e_dvld [2];
  int e_addr [2];
  int e_daddr [2];

  int plog [2][$];
  int dlog [2][$];
  int byp_cnt [2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input int m, input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL dut%0d %s: got %0d want %0d (t=%0t)", m, name, got, want, $time);
    end
  endtask

  // stable sorted insert: behind every entry of equal or smaller rank
  task automatic sorted_ins(input int m, input e_t ne);
    int pos = mq[m].size();
    for (int i = 0; i < mq[m].size(); i++) begin
      if (mq[m][i].rank > ne.rank) begin
        pos = i;
        break;
      end
    end
    mq[m].insert(pos, ne);
  endtask

  task automatic model_step(input int m);
    bit ins = ins_en && in_valid;
    e_t ne, old;
    ne.rank  = in_rank;
    ne.field = in_field;
    e_vld[m]  = 1'b0;
    e_byp[m]  = 1'b0;
    e_dvld[m] = 1'b0;
    if (ins && pop_en) begin
      e_vld[m] = 1'b1;
      if (mq[m].size() == 0 || ne.rank < mq[m][0].rank) begin
        e_byp[m]  = 1'b1;
        e_addr[m] = ne.field;
      end else begin
        old       = mq[m].pop_front();
        e_addr[m] = old.field;
        sorted_ins(m, ne);
      end
    end else if (pop_en) begin
      if (mq[m].size() > 0) begin
        old       = mq[m].pop_front();
        e_vld[m]  = 1'b1;
        e_addr[m] = old.field;
      end
    end else if (ins) begin
      if (mq[m].size() < SIZE) begin
        sorted_ins(m, ne);
      end else if (m == 0 || ne.rank >= mq[m][SIZE-1].rank) begin
        e_dvld[m]  = 1'b1;
        e_daddr[m] = ne.field;
      end else begin
        sorted_ins(m, ne);
        old        = mq[m].pop_back();
        e_dvld[m]  = 1'b1;
        e_daddr[m] = old.field;
      end
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int m = 0; m < 2; m++) begin
        mq[m].delete();
        e_vld[m] = 0; e_byp[m] = 0; e_dvld[m] = 0; e_addr[m] = 0; e_daddr[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) model_step(m);
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk(m, "addr_valid", int'(o_vld[m]), int'(e_vld[m]));
      chk(m, "buffer_addr", int'(o_addr[m]), e_addr[m]);
      chk(m, "bypass_en", int'(o_byp[m]), int'(e_byp[m]));
      chk(m, "drop_valid", int'(o_dvld[m]), int'(e_dvld[m]));
      chk(m, "drop_addr", int'(o_daddr[m]), e_daddr[m]);
      chk(m, "count", int'(o_cnt[m]), mq[m].size());
      chk(m, "full", int'(o_full[m]), int'(mq[m].size() == SIZE));
      chk(m, "empty", int'(o_empty[m]), int'(mq[m].size() == 0));
      if (o_vld[m])  plog[m].push_back(int'(o_addr[m]));
      if (o_dvld[m]) dlog[m].push_back(int'(o_daddr[m]));
      if (o_byp[m])  byp_cnt[m]++;
    end
  end

  task automatic drv(input bit i, input bit p, input bit v, input int r, input int f);
    ins_en   = i;
    pop_en   = p;
    in_valid = v;
    in_rank  = RW'(r);
    in_field = FW'(f);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 0);
  endtask

  task automatic ins(input int r, input int f);
    drv(1, 0, 1, r, f);
  endtask

  task automatic pops(input int n);
    for (int k = 0; k < n; k++) drv(0, 1, 0, 0, 0);
  endtask

  task automatic clear_logs();
    for (int m = 0; m < 2; m++) begin
      plog[m].delete();
      dlog[m].delete();
      byp_cnt[m] = 0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
    clear_logs();
  endtask

  function automatic int pat(input int m, input int k);
    return (k < plog[m].size()) ? plog[m][k] : -1;
  endfunction

  function automatic int dat(input int m, input int k);
    return (k < dlog[m].size()) ? dlog[m][k] : -1;
  endfunction

  initial begin
    int s1w [10];
    s1w = '{1, 11, 12, 13, 14, 15, 16, 17, 18, 19};

    idle(2);
    chk(0, "rst_count", int'(o_cnt[0]), 0);
    chk(0, "rst_empty", int'(o_empty[0]), 1);
    chk(1, "rst_full", int'(o_full[1]), 0);
    chk(1, "rst_addr", int'(o_addr[1]), 0);
    rstn = 1'b1;
    idle(1);
    clear_logs();

    // stable order among equal ranks
    ins(10, 1);
    for (int f = 11; f <= 19; f++) ins(10, f);
    chk(0, "s1_full", int'(o_full[0]), 1);
    pops(10);
    idle(1);
    chk(0, "s1_npops", plog[0].size(), 10);
    for (int k = 0; k < 10; k++) chk(0, "s1_order", pat(0, k), s1w[k]);
    chk(0, "s1_empty", int'(o_empty[0]), 1);

    // sorted insert
    do_reset();
    ins(1, 2); ins(20, 3); ins(15, 4);
    pops(3);
    idle(1);
    chk(0, "s2_p0", pat(0, 0), 2);
    chk(0, "s2_p1", pat(0, 1), 4);
    chk(0, "s2_p2", pat(0, 2), 3);
    chk(0, "s2_bypass", byp_cnt[0], 0);

    // insert + pop collisions
    do_reset();
    ins(15, 4); ins(20, 3);
    drv(1, 1, 1, 100, 6);
    chk(0, "s3_replace", pat(0, 0), 4);
    drv(1, 1, 1, 1, 7);
    chk(0, "s3_bypass_addr", int'(o_addr[0]), 7);
    chk(0, "s3_bypass_en", int'(o_byp[0]), 1);
    chk(0, "s3_count", int'(o_cnt[0]), 2);
    pops(2);
    idle(1);
    chk(0, "s3_rest0", pat(0, 2), 3);
    chk(0, "s3_rest1", pat(0, 3), 6);

    // full with drop-incoming
    do_reset();
    for (int k = 0; k < 10; k++) ins(10, 40 + k);
    ins(5, 30);
    chk(0, "s4_drop_vld", int'(o_dvld[0]), 1);
    chk(0, "s4_drop_addr", int'(o_daddr[0]), 30);
    chk(0, "s4_count", int'(o_cnt[0]), 10);
    pops(10);
    idle(1);
    for (int k = 0; k < 10; k++) chk(0, "s4_contents", pat(0, k), 40 + k);

    // full with evict-max
    do_reset();
    for (int k = 0; k < 10; k++) ins(10 + k, k);
    ins(5, 30);
    ins(50, 31);
    pops(1);
    idle(1);
    chk(1, "s5_evict", dat(1, 0), 9);
    chk(1, "s5_drop_new", dat(1, 1), 31);
    chk(1, "s5_head", pat(1, 0), 30);

    // empty pop, then reset during a pop burst
    do_reset();
    pops(2);
    idle(1);
    chk(0, "s6_empty_pop", plog[0].size(), 0);
    chk(0, "s6_empty_cnt", int'(o_cnt[0]), 0);
    for (int k = 0; k < 7; k++) ins(30, k);
    pops(2);
    chk(0, "s6_pre_cnt", int'(o_cnt[0]), 5);
    ins_en = 1'b0; pop_en = 1'b1; in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk(0, "s6_rst_cnt", int'(o_cnt[0]), 0);
    chk(1, "s6_rst_empty", int'(o_empty[1]), 1);
    clear_logs();
    pops(2);
    rstn = 1'b1;
    pops(3);
    idle(1);
    chk(0, "s6_no_pulse", plog[0].size(), 0);

    // randomized traffic in fill / balanced / drain phases
    for (int n = 0; n < 3000; n++) begin
      int ph, pi, pp, r;
      ph = (n / 150) % 3;
      pi = (ph == 0) ? 80 : (ph == 1) ? 50 : 20;
      pp = (ph == 0) ? 20 : (ph == 1) ? 50 : 80;
      r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << RW) - 1))
                                       : int'($urandom_range(0, 15));
      drv($urandom_range(0, 99) < pi, $urandom_range(0, 99) < pp,
          $urandom_range(0, 9) != 0, r, int'($urandom_range(0, (1 << FW) - 1)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pifo_calendar_v0_2.md
# pifo_calendar_v0_2

Parametrised successor to the root-only PIFO calendar. It holds up to DEPTH packet descriptors sorted by rank, with FIFO order among equal ranks, and pops the smallest rank first. Compared with the first generation it adds:
- configurable depth and field widths;
- a configurable full-policy (drop-tail or evict-max) with a drop report;
- empty and occupancy outputs;
- defined insert/pop-collision behaviour, including bypass.

It sits between the scheduler's rank computation and the packet-buffer read logic.

## Interface
Parameters:
- PIFO_CALENDAR_SIZE, 10, depth in entries (2..64).
- RANK_W, 19, rank width.
- FIELD_W, 12, buffer address/field width.
- FULL_MODE, 0, full-policy: 0 = drop incoming; 1 = evict largest rank if the incoming rank is strictly smaller.
- INFO_W, 1+RANK_W+FIELD_W, derived.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- s_axis_pifo_info_root  in  INFO_W  {valid, rank, field}, MSB = valid.
- s_axis_insert_en  in  1  insert request; effective only when the info valid bit is 1.
- s_axis_pop_en  in  1  pop request.
- m_axis_buffer_addr  out  FIELD_W  popped field.
- m_axis_buffer_addr_valid  out  1  one-cycle pulse per popped element.
- m_axis_bypass_en  out  1  the popped element came directly from the input.
- m_axis_drop_valid  out  1  one-cycle pulse when an element is discarded.
- m_axis_drop_addr  out  FIELD_W  field of the discarded element.
- m_axis_calendar_full  out  1  count == PIFO_CALENDAR_SIZE.
- m_axis_calendar_empty  out  1  count == 0.
- m_axis_count  out  $clog2(SIZE+1)  occupancy.

## Operation
Storage:
- Slot array 0..SIZE-1; slot 0 is the head. Valid slots are contiguous from 0.
- Sorting key is rank only, unsigned compare.

Definitions:
- ins = insert_en && info.valid.
- p = number of valid slots with rank <= new rank. This places a new element after existing equal ranks (stable FIFO order).

Actions per cycle, evaluated at posedge:
- **Idle** (!ins && !pop): hold.
- **Pop only**, not empty: output slot 0; slot i takes slot i+1; count−1.
- **Pop only**, empty: ignored; no pulse; state unchanged.
- **Insert only**, not full:
  - slots i<p hold;
  - slot p takes the new element;
  - slots i>p take slot i−1;
  - count+1.
- **Insert only**, full, FULL_MODE=0: drop the incoming element; drop_addr = its field.
- **Insert only**, full, FULL_MODE=1, p<SIZE: shift-insert as above; the old tail is discarded and reported on drop_addr.
- **Insert only**, full, FULL_MODE=1, p==SIZE: drop the incoming element.
- **Insert+pop, bypass**: applies when empty, or when new rank < slot0 rank (strict).
  - Output the new element; bypass_en=1.
  - Array unchanged.
- **Insert+pop, otherwise** (replace):
  - output slot 0;
  - slots i<p−1 take slot i+1;
  - slot p−1 takes the new element;
  - slots i>p−1 hold;
  - count unchanged;
  - never drops, even when full.

## Timing
Reset:
- Asynchronous.
- All slots are cleared to invalid and count=0.
- All pulse outputs are 0; addr outputs are 0.
- empty=1, full=0.

Output latency:
- Pop latency is 1 cycle. If request inputs are sampled at edge N, then buffer_addr, buffer_addr_valid and bypass_en are registered at edge N and held for the cycle after N.
- drop_valid/drop_addr are registered the same way.
- Without a new event, all pulses deassert at the next edge. addr outputs hold their last value.
- count, full and empty update at the same edge as the action.
- full and empty are decoded from the registered count; they are not combinational on the inputs.

Throughput:
- One insert and/or one pop per cycle; back-to-back requests in every cycle are supported.
- Asserting pop_en for k consecutive cycles yields min(k, count) pulses.
- Inputs are level-sampled per edge. A request held for one clock period is one request.

Reset mid-operation: all contents are lost and outputs return to reset values immediately.

## Structure
Shared package pifo_calendar_pkg:
- RANK_W and FIELD_W defaults.
- pifo_elem_t {valid, rank, field}.
- Field-offset constants for unpacking the info bus.
- FULL_MODE encodings: FULL_DROP_IN=0, FULL_EVICT_MAX=1.

Sub-module pifo_calendar_cell (one slot):
- Inputs: left and right neighbour elements, the new element, its own index, p, and the action select.
- Output: the next slot content.
- The top level computes p with a parallel compare-and-popcount and instantiates SIZE cells with a generate loop.

## Test plan
All scenarios use SIZE=10 unless stated otherwise.
1. **Stable order.** Insert fields 1,11..19 at rank 10, then 10 pops.
   - Fields come out 1,11,12..19, one per cycle; buffer_addr_valid is high 10 cycles.
   - full=1 after the 10th insert; empty=1 after the last pop.
2. **Sorted insert.** Insert (r1,f2), (r20,f3), (r15,f4), then 3 pops.
   - Output order f2, f4, f3; bypass_en=0 throughout.
3. **Collisions.** Queue holds (r15,f4) and (r20,f3).
   - Insert (r100,f6) + pop → outputs f4; queue becomes {f3,f6}.
   - Insert (r1,f7) + pop → outputs f7 with bypass_en=1; count unchanged at 2.
4. **Full, FULL_MODE=0.** Fill with rank 10, then insert (r5,f30).
   - drop_valid=1, drop_addr=30; count stays 10; contents unchanged.
5. **Full, FULL_MODE=1** (fill ranks 10..19, fields 0..9).
   - Insert (r5,f30) → drop_addr=9; head becomes f30.
   - Insert (r50,f31) → drop_addr=31.
6. **Empty pop and reset.**
   - Pop on empty → no pulse; count stays 0.
   - Assert rstn=0 mid-burst with count=5 → count=0 and empty=1 immediately; no pulses after rstn deasserts.
